// File: rtl/tdes_sequencer.sv
// Pass/round sequencer for the iterative Triple-DES core: runs E-D-E or D-E-D over one
// shared round datapath (keying option 2) and pulses des_ready when the result is valid.
module tdes_sequencer #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             dir_sel,
  input  logic             abort,
  output logic             busy,
  output logic             core_load,
  output logic             src_sel,
  output logic             round_en,
  output logic [IDX_W-1:0] subkey_idx,
  output logic             pass_dec,
  output logic             key1_act,
  output logic             key2_act,
  output logic             pass_end,
  output logic             des_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINISH,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(ROUNDS - 1);

  state_t           r_state,     w_state_nxt;
  logic [1:0]       r_pass_cnt,  w_pass_nxt;
  logic [IDX_W-1:0] r_round_cnt, w_round_nxt;
  logic             r_dir_q,     w_dir_nxt;
  logic             w_in_pass;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_pass_cnt  <= '0;
      r_round_cnt <= '0;
      r_dir_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pass_cnt  <= w_pass_nxt;
      r_round_cnt <= w_round_nxt;
      r_dir_q     <= w_dir_nxt;
    end
  end

  // NOTE: every variable gets a hold/default value first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass_cnt;
    w_round_nxt = r_round_cnt;
    w_dir_nxt   = r_dir_q;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_pass_nxt  = '0;
      w_round_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_LOAD;
            w_dir_nxt   = dir_sel;
            w_pass_nxt  = '0;
          end
        end
        S_LOAD: begin
          w_state_nxt = S_ROUND;
          w_round_nxt = '0;
        end
        S_ROUND: begin
          if (r_round_cnt == LAST_RND) w_state_nxt = S_FINISH;
          else                         w_round_nxt = r_round_cnt + 1'b1;
        end
        S_FINISH: begin
          if (r_pass_cnt == 2'd2) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
            w_pass_nxt  = r_pass_cnt + 1'b1;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_pass_nxt  = '0;
          w_round_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_pass_nxt  = '0;
          w_round_nxt = '0;
        end
      endcase
    end
  end

  // Moore outputs: pure decode of registered state, so reset clears them without a clock.
  assign w_in_pass  = (r_state == S_LOAD) || (r_state == S_ROUND) || (r_state == S_FINISH);
  assign busy       = (r_state != S_IDLE);
  assign core_load  = (r_state == S_LOAD);
  assign round_en   = (r_state == S_ROUND);
  assign pass_end   = (r_state == S_FINISH);
  assign des_ready  = (r_state == S_DONE);
  assign pass_dec   = w_in_pass && (r_dir_q ^ (r_pass_cnt == 2'd1));
  assign key1_act   = w_in_pass && (r_pass_cnt != 2'd1);
  assign key2_act   = w_in_pass && (r_pass_cnt == 2'd1);
  assign src_sel    = w_in_pass && (r_pass_cnt != 2'd0);
  assign subkey_idx = !round_en ? '0 :
                      pass_dec  ? (LAST_RND - r_round_cnt) : r_round_cnt;

endmodule

// File: tb/tb_tdes_sequencer.sv
// Self-checking bench for tdes_sequencer: directed scenarios plus random start/abort/dir
// traffic, compared every cycle against a cycle-offset timeline model.
module tb_tdes_sequencer;

  localparam int ROUNDS = 16;
  localparam int IDX_W  = 4;
  localparam int P      = ROUNDS + 2;
  localparam int LAT    = 3 * P + 1;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start, dir_sel, abort;
  logic             busy, core_load, src_sel, round_en, pass_dec;
  logic             key1_act, key2_act, pass_end, des_ready;
  logic [IDX_W-1:0] subkey_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int m_t      = 0;      // cycles since accepted start (0 = idle)
  logic m_dir  = 1'b0;
  int m_ready  = 0;
  int o_ready  = 0;

  tdes_sequencer #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .dir_sel    (dir_sel),
    .abort      (abort),
    .busy       (busy),
    .core_load  (core_load),
    .src_sel    (src_sel),
    .round_en   (round_en),
    .subkey_idx (subkey_idx),
    .pass_dec   (pass_dec),
    .key1_act   (key1_act),
    .key2_act   (key2_act),
    .pass_end   (pass_end),
    .des_ready  (des_ready)
  );

  always #5 clk = ~clk;

  wire [12:0] w_outs = {busy, core_load, src_sel, round_en, subkey_idx,
                        pass_dec, key1_act, key2_act, pass_end, des_ready};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs from the position inside the 3-pass timeline.
  function automatic logic [12:0] exp_outs(input int t, input logic dir);
    int p, k;
    logic b, ld, src, re, dec, k1, k2, pe, rdy;
    logic [IDX_W-1:0] sk;
    {b, ld, src, re, dec, k1, k2, pe, rdy} = '0;
    sk = '0;
    if (t == LAT) begin
      b = 1'b1; rdy = 1'b1;
    end else if (t >= 1 && t < LAT) begin
      p   = (t - 1) / P;
      k   = (t - 1) % P;
      b   = 1'b1;
      ld  = (k == 0);
      pe  = (k == P - 1);
      re  = (k >= 1 && k <= ROUNDS);
      dec = dir ^ (p == 1);
      k1  = (p != 1);
      k2  = (p == 1);
      src = (p != 0);
      if (re) sk = dec ? IDX_W'(ROUNDS - k) : IDX_W'(k - 1);
    end
    return {b, ld, src, re, sk, dec, k1, k2, pe, rdy};
  endfunction

  task automatic model_step(input logic s, input logic a, input logic d);
    if (a)              m_t = 0;
    else if (m_t == 0) begin
      if (s) begin m_t = 1; m_dir = d; end
    end
    else if (m_t == LAT) m_t = 0;
    else                 m_t++;
    if (m_t == LAT) m_ready++;
  endtask

  // One clock: drive on falling edge, step model at rising edge, check 1 ns later.
  task automatic step(input logic s, input logic a, input logic d);
    @(negedge clk);
    start = s; abort = a; dir_sel = d;
    @(posedge clk);
    cyc++;
    if (!n_rst) begin m_t = 0; m_dir = 1'b0; end
    else        model_step(s, a, d);
    #1;
    if (des_ready === 1'b1) o_ready++;
    check($sformatf("outs@%0d", cyc), 32'(w_outs), 32'(exp_outs(m_t, m_dir)));
  endtask

  task automatic async_reset();
    #2 n_rst = 1'b0;
    #1 check("async_rst_outs", 32'(w_outs), 32'd0);
    m_t = 0; m_dir = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    n_rst = 1'b1;
  endtask

  initial begin
    int lat, r0;
    n_rst = 1'b0; start = 1'b1; dir_sel = 1'b1; abort = 1'b0;

    // Reset held with start asserted
    #1 check("rst_outs", 32'(w_outs), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    #2 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Encrypt with explicit latency measurement
    step(1'b1, 1'b0, 1'b0);
    lat = 1;
    while (des_ready !== 1'b1 && lat < LAT + 15) begin
      step(1'b0, 1'b0, 1'b0);
      lat++;
    end
    check("enc_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Decrypt, dir_sel flips to 0 at cycle 10 of the run
    step(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= LAT + 2; i++) step(1'b0, 1'b0, (i < 10));

    // Abort in pass 1 ROUND, then restart
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 25; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("abort_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0, 1'b0);

    // start together with abort in IDLE stays IDLE
    step(1'b1, 1'b1, 1'b0);
    check("start_abort_idle", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high
    r0 = o_ready;
    for (int i = 0; i < 2 * (LAT + 1); i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check("b2b_ready_count", 32'(o_ready - r0), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Async reset mid-pass, then a normal run
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 30; i++) step(1'b0, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    lat = 1;
    while (des_ready !== 1'b1 && lat < LAT + 15) begin
      step(1'b0, 1'b0, 1'b0);
      lat++;
    end
    check("post_rst_latency", 32'(lat), 32'(LAT));

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 90) == 0), 1'($urandom_range(0, 1)));

    check("ready_total", 32'(o_ready), 32'(m_ready));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdes_sequencer.md
# tdes_sequencer

Pass and round sequencer for the iterative Triple-DES core. On a start request it runs three DES passes (E-D-E for encryption, D-E-D for decryption) over the single shared round datapath, driving key selection, subkey index, per-pass direction and load/feedback controls, then pulses `des_ready` for the main SRAM controller. Keying option 2: passes 0 and 2 use K1, pass 1 uses K2.

## Interface
- `ROUNDS`, 16: DES rounds per pass; must satisfy ROUNDS ≤ 2**IDX_W.
- `IDX_W`, 4: width of the subkey index.

- `clk`  in  1  system clock, all state updates on rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request a 3-pass operation; sampled only in IDLE
- `dir_sel`  in  1  0 = encrypt, 1 = decrypt; captured with accepted `start`
- `abort`  in  1  synchronous cancel (driven from I2C stop); any state → IDLE
- `busy`  out  1  high in every state except IDLE
- `core_load`  out  1  load core L/R registers (after IP) this cycle
- `src_sel`  out  1  core load source: 0 = input block register, 1 = core output feedback
- `round_en`  out  1  core executes one round this cycle
- `subkey_idx`  out  IDX_W  subkey number for the current round
- `pass_dec`  out  1  current pass is a decrypt pass
- `key1_act`  out  1  K1 selected for key schedule
- `key2_act`  out  1  K2 selected for key schedule
- `pass_end`  out  1  core applies final swap/FP into its pass-result register
- `des_ready`  out  1  one-cycle pulse: 3DES result valid in core output

## Operation
- States: IDLE, LOAD, ROUND, FINISH, DONE. Counters: `pass_cnt` (0..2), `round_cnt` (0..ROUNDS-1). Register `dir_q`.
- IDLE: `start`=1 and `abort`=0 → capture `dir_q`=`dir_sel`, `pass_cnt`=0 → LOAD.
- LOAD (1 cycle): `round_cnt`=0 → ROUND.
- ROUND (ROUNDS cycles): `round_cnt` increments; at ROUNDS-1 → FINISH.
- FINISH (1 cycle): `pass_cnt`<2 → increment, LOAD; `pass_cnt`=2 → DONE.
- DONE (1 cycle) → IDLE.
- `abort`=1 in any state → IDLE next edge, counters cleared, no `des_ready`. In IDLE, `abort` beats `start`.
- `start` outside IDLE ignored (not queued). `dir_sel` ignored outside IDLE.
- Outputs are Moore: decoded from state, `pass_cnt`, `dir_q`, `round_cnt` only; no input-to-output paths.
  - `pass_dec` = `dir_q` XOR (`pass_cnt`==1), in LOAD/ROUND/FINISH; else 0.
  - `key1_act` = (`pass_cnt`≠1), `key2_act` = (`pass_cnt`==1), both only in LOAD/ROUND/FINISH; else 0.
  - `src_sel` = (`pass_cnt`≠0) in LOAD/ROUND/FINISH; else 0.
  - `subkey_idx` = `pass_dec` ? ROUNDS-1-`round_cnt` : `round_cnt` in ROUND; 0 elsewhere.
  - `core_load`, `round_en`, `pass_end`, `des_ready` high only in LOAD, ROUND, FINISH, DONE respectively.
- Reset: state IDLE, counters 0, `dir_q`=0; every output 0.

## Timing
- Cycle 0 = edge sampling `start`. Pass p (0..2) occupies cycles p·(ROUNDS+2)+1 … (p+1)·(ROUNDS+2): LOAD, ROUNDS×ROUND, FINISH.
- Default ROUNDS=16: LOAD at 1/19/37, ROUND 2–17/20–35/38–53, FINISH 18/36/54, `des_ready` cycle 55, IDLE cycle 56.
- Latency start → `des_ready`: 3·(ROUNDS+2)+1 cycles (55). Minimum start-to-start period 3·(ROUNDS+2)+2 (56): `start` held high is re-accepted in cycle 56.
- `abort` sampled high in cycle n → IDLE and all outputs 0 in cycle n+1.
- `n_rst` low forces outputs 0 immediately, independent of `clk`.

## Test plan
- Reset: hold `n_rst`=0 with `start`=1 → all outputs 0, `busy`=0; release → IDLE until `start`.
- Encrypt (`dir_sel`=0): `core_load` at 1/19/37, `src_sel` 0/1/1, `pass_dec` 0/1/0, `subkey_idx` 0→15 pass 0, 15→0 pass 1, 0→15 pass 2; `key2_act` exactly cycles 19–36; `key1_act` 1–18 and 37–54; `des_ready` only cycle 55.
- Decrypt (`dir_sel`=1, toggled to 0 at cycle 10): `pass_dec` 1/0/1 for full run, subkey orders mirror encrypt case, `des_ready` cycle 55.
- Abort: `abort`=1 at cycle 25 (pass 1 ROUND) → cycle 26 all outputs 0, `busy`=0, no `des_ready`; `start` at cycle 27 gives `des_ready` at 82. `start`+`abort` together in IDLE → stays IDLE.
- Back-to-back: `start` held high → `des_ready` at 55 and 111 only; extra pulses of `start` during busy do nothing.
- Async reset at cycle 30 mid-pass → outputs 0 before next edge; restart gives normal 55-cycle latency.
